seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
//  Runtime-programmable serial sequence detector; parametrised successor to the fixed 6-state Mealy detectors.
//  Detects a loadable pattern of 2..MAX_LEN bits on serial input w.
//  Supports overlapping and non-overlapping modes, an input-enable stall and a saturating match counter.
//  Sits between the serial bit source and the lab status/LED logic.
// PARAMETERS
//  MAX_LEN  8  maximum pattern length in bits (>=2)
//  CNT_W    8  width of match_count
// PORTS
//  clk          in   1                    clock, rising edge
//  reset        in   1                    asynchronous, active-high reset
//  en           in   1                    sample w this cycle; low = stall, nothing changes
//  w            in   1                    serial data bit
//  cfg_load     in   1                    1-cycle strobe: latch cfg_* and restart detection
//  cfg_pattern  in   MAX_LEN              pattern; bit [len-1] is the oldest bit, bit [0] the newest
//  cfg_len      in   $clog2(MAX_LEN+1)    pattern length
//  cfg_overlap  in   1                    1 = overlapping matches, 0 = non-overlapping
//  cnt_clr      in   1                    synchronous clear of match_count
//  z            out  1                    Mealy match, combinational from state, hist, w and en
//  z_q          out  1                    z registered one cycle later
//  match_count  out  CNT_W                saturating count of matches
//  state_o      out  2                    current FSM state: 0 IDLE, 1 FILL, 2 RUN
// BEHAVIOUR
//  Reset values: state IDLE; hist, fill_cnt, len, pattern, overlap, z_q and match_count all 0.
//  z is 0 while reset is asserted.
//  Registers: hist[MAX_LEN-2:0] holds past bits, newest in [0]. fill_cnt counts bits captured since restart.
//  cfg_load has priority over everything else:
//   - latch pattern and overlap; len = clamp(cfg_len, 2, MAX_LEN).
//   - clear hist and fill_cnt; state goes to FILL; z=0 that cycle.
//  IDLE: never configured; z=0; en ignored; left only via cfg_load.
//  FILL, on en=1:
//   - hist shifts in w and fill_cnt increments.
//   - when fill_cnt reaches len-1, go to RUN.
//   - z=0 throughout FILL.
//  RUN, on en=1: z = ({hist[len-2:0], w} == pattern[len-1:0]).
//   - hist always shifts in w.
//   - z=1 and overlap=1: stay in RUN.
//   - z=1 and overlap=0: clear hist, fill_cnt=0, go to FILL. The matching bit is not reused.
//   - z=0: stay in RUN.
//  en=0: z=0; hist, fill_cnt and state hold.
//  z_q <= z every clk. Latency: z_q follows z by one cycle.
//  match_count:
//   - increments on each cycle with z=1; saturates at 2^CNT_W-1, no wrap.
//   - cnt_clr=1 forces 0, with priority over a simultaneous match.
//   - cfg_load does not clear it.
//  Asynchronous reset mid-stream returns to IDLE immediately; the pattern must be reloaded.
//  Only bits [len-1:0] of the pattern are compared; upper bits are don't-care.
// TESTING
//  1. Load 3'b111, len=3, overlap=1; drive w=1,1,1,1,1 -> z=0,0,1,1,1; match_count=3.
//  2. Same pattern with overlap=0; drive w=1 x6 -> z high on bits 3 and 6 only; match_count=2.
//  3. Load 4'b1001, len=4, overlap=1; drive 1,0,0,1,0,0,1 -> z on bits 4 and 7.
//     Same stream with overlap=0 -> z on bit 4 only.
//  4. Pattern 1001 with en=0 gaps inserted between bits -> same z sequence as test 3; z=0 on every stalled cycle.
//  5. CNT_W=2, pattern 11 overlap, drive 6 ones -> match_count saturates at 3.
//     Then assert cnt_clr on a match cycle -> match_count=0.
//  6. Assert reset mid-match -> state IDLE, z_q=0, count=0; ones afterwards give z=0 until cfg_load.
//     Also: cfg_len=0 and cfg_len=15 are clamped to 2 and MAX_LEN.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector.
// Matches a loadable pattern of 2..MAX_LEN bits on the serial input w,
// with overlapping / non-overlapping modes, an input stall (en) and a
// saturating match counter. z is a Mealy output; z_q is z one cycle later.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         w,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         cnt_clr,
  output logic                         z,
  output logic                         z_q,
  output logic [CNT_W-1:0]             match_count,
  output logic [1:0]                   state_o
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Length is forced into the legal range 2..MAX_LEN so the compare window
  // and the fill threshold are always meaningful.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l < LEN_W'(2))
      return LEN_W'(2);
    if (l > LEN_W'(MAX_LEN))
      return LEN_W'(MAX_LEN);
    return l;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c == {CNT_W{1'b1}})
      return c;
    return c + CNT_W'(1);
  endfunction

  state_t               state, state_n;
  logic [MAX_LEN-2:0]   hist, hist_n;
  logic [LEN_W-1:0]     fill_cnt, fill_n;
  logic [LEN_W-1:0]     len, len_n;
  logic [MAX_LEN-1:0]   pattern, pattern_n;
  logic                 overlap, overlap_n;

  // Candidate window: stored history with the current bit appended as newest.
  logic [MAX_LEN-1:0]   window;
  logic [MAX_LEN-1:0]   len_mask;
  logic                 window_hit;

  assign window     = {hist, w};
  // Only the low len bits take part; older history and upper pattern bits
  // are don't-care. Shifting by len == MAX_LEN yields an all-ones mask.
  assign len_mask   = ~({MAX_LEN{1'b1}} << len);
  assign window_hit = (((window ^ pattern) & len_mask) == '0);
  assign state_o    = state;

  // State and configuration registers; everything returns to zero / IDLE
  // on reset so a reset mid-stream forces a reload of the pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hist     <= '0;
      fill_cnt <= '0;
      len      <= '0;
      pattern  <= '0;
      overlap  <= 1'b0;
    end else begin
      state    <= state_n;
      hist     <= hist_n;
      fill_cnt <= fill_n;
      len      <= len_n;
      pattern  <= pattern_n;
      overlap  <= overlap_n;
    end
  end

  // Next-state and Mealy output: cfg_load wins, then en gates any progress.
  always_comb begin
    state_n   = state;
    hist_n    = hist;
    fill_n    = fill_cnt;
    len_n     = len;
    pattern_n = pattern;
    overlap_n = overlap;
    z         = 1'b0;

    if (cfg_load) begin
      pattern_n = cfg_pattern;
      overlap_n = cfg_overlap;
      len_n     = clamp_len(cfg_len);
      hist_n    = '0;
      fill_n    = '0;
      state_n   = FILL;
    end else if (en) begin
      case (state)
        FILL: begin
          hist_n = window[MAX_LEN-2:0];
          fill_n = fill_cnt + LEN_W'(1);
          // len-1 bits of history are enough; the next bit completes a window.
          if (fill_n == (len - LEN_W'(1)))
            state_n = RUN;
        end
        RUN: begin
          z      = window_hit & ~reset;
          hist_n = window[MAX_LEN-2:0];
          // Non-overlapping: the matching bit is consumed, start refilling.
          if (window_hit && !overlap) begin
            hist_n  = '0;
            fill_n  = '0;
            state_n = FILL;
          end
        end
        default: begin
          // IDLE: not configured yet, input ignored.
          state_n = state;
        end
      endcase
    end
  end

  // One-cycle delayed copy of the match pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      z_q <= 1'b0;
    else
      z_q <= z;
  end

  // Saturating match counter; clear beats a simultaneous match and
  // reconfiguration leaves it untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      match_count <= '0;
    else if (cnt_clr)
      match_count <= '0;
    else if (z)
      match_count <= sat_inc(match_count);
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed testbench for seq_detector_prog: table of per-cycle vectors plus
// hand-written sequences for counter saturation and mid-stream reset.
module tb_seq_detector_prog;

  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] SF = 2'd1;
  localparam logic [1:0] SR = 2'd2;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       w;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;

  logic       z, z_q;
  logic [7:0] match_count;
  logic [1:0] state_o;

  logic       z2, z_q2;
  logic [1:0] match_count2;
  logic [1:0] state_o2;

  int n_checks = 0;
  int n_pass   = 0;

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z), .z_q(z_q), .match_count(match_count),
    .state_o(state_o)
  );

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .w(w), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .z(z2), .z_q(z_q2), .match_count(match_count2),
    .state_o(state_o2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cl;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       clr;
    logic       en;
    logic       w;
    logic       ez;
    logic [7:0] ec;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t V(int cl, int pat, int len, int ovl, int clr,
                             int e, int b, int ez, int ec, int es);
    vec_t v;
    v.cl  = cl[0];
    v.pat = pat[7:0];
    v.len = len[3:0];
    v.ovl = ovl[0];
    v.clr = clr[0];
    v.en  = e[0];
    v.w   = b[0];
    v.ez  = ez[0];
    v.ec  = ec[7:0];
    v.es  = es[1:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at posedge+1: drive, check z mid-cycle, then registered outputs.
  task automatic run_vec(input vec_t v, input string tag);
    cfg_load    = v.cl;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    cnt_clr     = v.clr;
    en          = v.en;
    w           = v.w;
    @(negedge clk);
    chk({tag, " z"}, 32'(z), 32'(v.ez));
    @(posedge clk);
    #1;
    chk({tag, " z_q"}, 32'(z_q), 32'(v.ez));
    chk({tag, " count"}, 32'(match_count), 32'(v.ec));
    chk({tag, " state"}, 32'(state_o), 32'(v.es));
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; w = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; cnt_clr = 1'b0;

    // Test 1: 111 (upper bits set to prove they are ignored), overlapping.
    vecs.push_back(V(1, 'hF7, 3, 1, 0, 0, 0, 0, 0, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 0, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 0, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 1, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 2, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 3, SR));
    // Test 2: same pattern, non-overlapping; cfg_load keeps the count.
    vecs.push_back(V(1, 'h07, 3, 0, 0, 0, 0, 0, 3, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 3, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 3, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 4, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 4, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 4, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 5, SF));
    // Test 3a: 1001 overlapping, stream 1001001.
    vecs.push_back(V(1, 'h09, 4, 1, 0, 0, 0, 0, 5, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 5, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 5, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 5, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 6, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 6, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 6, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 7, SR));
    // Test 3b: same stream, non-overlapping.
    vecs.push_back(V(1, 'h09, 4, 0, 0, 0, 0, 0, 7, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 7, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 7, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 7, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 8, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 8, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 8, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 8, SR));
    // Test 4: 1001 overlapping with en=0 stalls carrying w=1 between bits.
    vecs.push_back(V(1, 'h09, 4, 1, 0, 0, 0, 0, 8, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 8, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 8, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 8, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 8, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 8, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 8, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 9, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 9, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 9, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 9, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 9, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 0, 1, 0, 9, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 10, SR));
    vecs.push_back(V(0, 0, 0, 0, 1, 0, 0, 0, 0, SR));
    // Clamp: cfg_len=0 acts as length 2.
    vecs.push_back(V(1, 'hFF, 0, 1, 0, 0, 0, 0, 0, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 0, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 1, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 1, SR));
    // Clamp: cfg_len=15 acts as length 8; pattern 10100101.
    vecs.push_back(V(1, 'hA5, 15, 1, 0, 0, 0, 0, 1, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 1, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 1, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 1, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 1, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 1, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 0, 1, SF));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 0, 0, 1, SR));
    vecs.push_back(V(0, 0, 0, 0, 0, 1, 1, 1, 2, SR));

    // Reset state, with en/w active to show IDLE ignores them.
    en = 1'b1; w = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 32'(state_o), 32'(SI));
    chk("reset z", 32'(z), 32'd0);
    chk("reset z_q", 32'(z_q), 32'd0);
    chk("reset count", 32'(match_count), 32'd0);
    reset = 1'b0;
    run_vec(V(0, 0, 0, 0, 0, 1, 1, 0, 0, SI), "idle ignores en");

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Test 5: CNT_W=2 instance saturates at 3 with pattern 11 overlapping.
    run_vec(V(1, 'h03, 2, 1, 1, 0, 0, 0, 0, SF), "sat load");
    chk("sat load cnt2", 32'(match_count2), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      run_vec(V(0, 0, 0, 0, 0, 1, 1, (k > 1) ? 1 : 0, k - 1, SR),
              $sformatf("sat bit%0d", k));
      chk($sformatf("sat bit%0d cnt2", k), 32'(match_count2),
          32'((k - 1 > 3) ? 3 : k - 1));
    end
    // Clear on a match cycle wins over the increment.
    run_vec(V(0, 0, 0, 0, 1, 1, 1, 1, 0, SR), "clr on match");
    chk("clr on match cnt2", 32'(match_count2), 32'd0);
    run_vec(V(0, 0, 0, 0, 0, 1, 1, 1, 1, SR), "match after clr");

    // Test 6: asynchronous reset in the middle of a matching cycle.
    en = 1'b1; w = 1'b1;
    @(negedge clk);
    chk("pre-reset z", 32'(z), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("async reset state", 32'(state_o), 32'(SI));
    chk("async reset z", 32'(z), 32'd0);
    chk("async reset z_q", 32'(z_q), 32'd0);
    chk("async reset count", 32'(match_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++)
      run_vec(V(0, 0, 0, 0, 0, 1, 1, 0, 0, SI), $sformatf("post-reset%0d", k));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
